// File: rtl/input_buf_pkg.sv
// Shared definitions for the double-buffered input tile scheduler.
package input_buf_pkg;

  localparam int unsigned NUM_BANK = 2;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/input_bank_fsm.sv
// Per-bank lifecycle (EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY) and drain timer.
module input_bank_fsm
  import input_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_start,
  input  logic                  drain_start,
  input  logic                  wr_done,
  input  logic [DATA_WIDTH-1:0] num_row,
  output logic [1:0]            state,
  output logic                  full
);

  localparam int unsigned CntW = DATA_WIDTH + 1;

  bank_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state and drain countdown; the counter holds the DRAINING cycles still to come.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (fill_start) state_d = FILLING;
      end
      FILLING: begin
        if (wr_done) state_d = FULL;
      end
      FULL: begin
        if (drain_start) begin
          state_d = DRAINING;
          // 2N-1 draining cycles including the first one, so 2N-2 remain after it.
          cnt_d   = {num_row, 1'b0} - CntW'(2);
        end
      end
      DRAINING: begin
        if (cnt_q == '0) state_d = EMPTY;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign full  = (state_q == FULL);

endmodule

// File: rtl/input_buf_sched.sv
// Ping-pong scheduler for two input buffer banks: grants tile fills and array drains.
// Optional sticky error flag enabled by defining INPUT_BUF_SCHED_ERR_EN.
module input_buf_sched
  import input_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACCUM_ROW  = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fill_req,
  input  logic [DATA_WIDTH-1:0]          fill_rows,
  output logic                           fill_gnt,
  input  logic                           cmp_req,
  output logic                           cmp_gnt,
  output logic [NUM_BANK-1:0]            wr_start,
  output logic [NUM_BANK-1:0]            rd_start,
  output logic [NUM_BANK*DATA_WIDTH-1:0] bank_num_row,
  input  logic [NUM_BANK-1:0]            wr_done_in,
  output logic [NUM_BANK-1:0]            bank_full,
  output logic                           err
);

  localparam logic [DATA_WIDTH-1:0] AccumRowW = DATA_WIDTH'(ACCUM_ROW);

  logic                  fp_q, rp_q;
  logic                  fill_gnt_q, cmp_gnt_q;
  logic [NUM_BANK-1:0]   wr_start_q, rd_start_q;
  logic [DATA_WIDTH-1:0] num_row_q [NUM_BANK];
  logic [1:0]            bank_state [NUM_BANK];

  logic                  fill_ok, cmp_ok;
  logic [NUM_BANK-1:0]   fill_sel, drain_sel;
  logic [DATA_WIDTH-1:0] rows_clamped;

  // Grant decisions. A request whose grant pulse is being presented this cycle is
  // already consumed, so it cannot win a second bank while the requester still holds it.
  always_comb begin
    fill_ok   = fill_req && (fill_rows != '0) && !fill_gnt_q && (bank_state[fp_q] == EMPTY);
    cmp_ok    = cmp_req && !cmp_gnt_q && (bank_state[rp_q] == FULL);
    fill_sel  = '0;
    drain_sel = '0;
    fill_sel[fp_q]  = fill_ok;
    drain_sel[rp_q] = cmp_ok;
    rows_clamped = (fill_rows > AccumRowW) ? AccumRowW : fill_rows;
  end

  // Registered grant pulses, bank pointers and latched row counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      fp_q       <= 1'b0;
      rp_q       <= 1'b0;
      fill_gnt_q <= 1'b0;
      cmp_gnt_q  <= 1'b0;
      wr_start_q <= '0;
      rd_start_q <= '0;
      for (int b = 0; b < NUM_BANK; b++) num_row_q[b] <= '0;
    end else begin
      fill_gnt_q <= fill_ok;
      cmp_gnt_q  <= cmp_ok;
      wr_start_q <= fill_sel;
      rd_start_q <= drain_sel;
      if (fill_ok) begin
        fp_q            <= ~fp_q;
        num_row_q[fp_q] <= rows_clamped;
      end
      if (cmp_ok) rp_q <= ~rp_q;
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    input_bank_fsm #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .fill_start  (fill_sel[b]),
      .drain_start (drain_sel[b]),
      .wr_done     (wr_done_in[b]),
      .num_row     (num_row_q[b]),
      .state       (bank_state[b]),
      .full        (bank_full[b])
    );
    assign bank_num_row[b*DATA_WIDTH +: DATA_WIDTH] = num_row_q[b];
  end

  assign fill_gnt = fill_gnt_q;
  assign cmp_gnt  = cmp_gnt_q;
  assign wr_start = wr_start_q;
  assign rd_start = rd_start_q;

`ifdef INPUT_BUF_SCHED_ERR_EN
  logic err_q;
  logic err_set;

  // Protocol violations: bad row count on a request, or write-done for a bank not filling.
  always_comb begin
    err_set = fill_req && ((fill_rows == '0) || (fill_rows > AccumRowW));
    for (int b = 0; b < NUM_BANK; b++) begin
      if (wr_done_in[b] && (bank_state[b] != FILLING)) err_set = 1'b1;
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
